// File: rtl/seq_pkg.sv
// Shared types and sequence helpers for the stream sequence checker.
package seq_pkg;

  typedef enum logic {
    SYNC  = 1'b0,
    CHECK = 1'b1
  } seq_state_e;

  typedef enum logic {
    MODE_CNT  = 1'b0,
    MODE_LFSR = 1'b1
  } seq_mode_e;

  // Maximal-length Galois taps (right-shift form) for the supported widths.
  function automatic logic [63:0] lfsr_taps(input int unsigned width);
    logic [63:0] taps;
    case (width)
      8:       taps = 64'h0000_0000_0000_00B8;
      16:      taps = 64'h0000_0000_0000_B400;
      32:      taps = 64'h0000_0000_A300_0000;
      default: taps = 64'hD800_0000_0000_0000;
    endcase
    return taps;
  endfunction

  // Successor of x in the selected sequence; x is zero-extended, result is masked to width.
  function automatic logic [63:0] seq_next(input seq_mode_e mode, input logic [63:0] x,
                                           input int unsigned width);
    logic [63:0] mask;
    logic [63:0] nxt;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    if (mode == MODE_CNT) begin
      nxt = x + 64'd1;
    end else begin
      nxt = (x >> 1) ^ (x[0] ? lfsr_taps(width) : 64'd0);
    end
    return nxt & mask;
  endfunction

endpackage

// File: rtl/stream_seq_checker_if.sv
// Valid/ready stream bundle between an upstream source and the checker.
interface stream_seq_checker_if #(
  parameter int unsigned D_WIDTH = 32
);
  logic               s_valid;
  logic [D_WIDTH-1:0] s_data;
  logic               s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/ready_throttle.sv
// Ready divider: asserts ready one cycle in every (div+1); div is re-read when the count wraps.
module ready_throttle (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [7:0] cfg_ready_div,
  output logic       ready
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] div_q, div_d;
  logic [7:0] limit;
  logic       ready_q, ready_d;

  // Next count; the divisor is sampled at count 0 and held for the rest of the period.
  always_comb begin
    limit   = (cnt_q == 8'd0) ? cfg_ready_div : div_q;
    div_d   = limit;
    cnt_d   = (cnt_q >= limit) ? 8'd0 : cnt_q + 8'd1;
    ready_d = (cnt_q == 8'd0);
  end

  // Divider state; clr behaves like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q   <= 8'd0;
      div_q   <= 8'd0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

endmodule

// File: rtl/stream_seq_checker.sv
// Self-synchronising stream checker (counter / Galois LFSR) with lock, error and LED status.
// Optional gap statistics are built when STREAM_SEQ_CHECKER_GAP_STATS_EN is defined;
// otherwise gap_max is tied to 0.
module stream_seq_checker
  import seq_pkg::*;
#(
  parameter int unsigned D_WIDTH        = 32,
  parameter int unsigned ERR_W          = 16,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned LOCK_GOOD      = 8,
  parameter int unsigned LOCK_MISS      = 4,
  parameter int unsigned HB_SHIFT       = 20,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 cfg_mode,
  input  logic [7:0]           cfg_ready_div,
  stream_seq_checker_if.slave  s,
  output logic                 lock,
  output logic                 err_sticky,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [15:0]          gap_max,
  output logic [3:0]           leds
);

  localparam int unsigned GoodW = $clog2(LOCK_GOOD + 1);
  localparam int unsigned MissW = $clog2(LOCK_MISS + 1);

  seq_state_e         state_q, state_d;
  seq_mode_e          mode_q, mode_d;
  seq_mode_e          cfg_mode_sel;
  logic [D_WIDTH-1:0] exp_q, exp_d;
  logic [GoodW-1:0]   good_q, good_d;
  logic [MissW-1:0]   miss_q, miss_d;
  logic               lock_q, lock_d;
  logic               ever_lock_q, ever_lock_d;
  logic               err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               hb_q, hb_d;
  logic               msb_q, msb_d;
  logic               xfer;

  ready_throttle u_throttle (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .cfg_ready_div (cfg_ready_div),
    .ready         (s.s_ready)
  );

  assign xfer         = s.s_valid && s.s_ready;
  assign cfg_mode_sel = seq_mode_e'(cfg_mode);

  // Sequence tracking, lock hysteresis and status counters.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    exp_d        = exp_q;
    good_d       = good_q;
    miss_d       = miss_q;
    lock_d       = lock_q;
    ever_lock_d  = ever_lock_q;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    word_cnt_d   = word_cnt_q;
    hb_d         = hb_q;
    msb_d        = msb_q;
    if (xfer) begin
      word_cnt_d = word_cnt_q + 1'b1;
      msb_d      = s.s_data[D_WIDTH-1];
      if (word_cnt_d[HB_SHIFT-1:0] == '0) hb_d = ~hb_q;
      unique case (state_q)
        SYNC: begin
          // An all-zero LFSR seed would lock the generator at zero, so it is ignored.
          if (!(cfg_mode_sel == MODE_LFSR && s.s_data == '0)) begin
            mode_d  = cfg_mode_sel;
            exp_d   = D_WIDTH'(seq_next(cfg_mode_sel, 64'(s.s_data), D_WIDTH));
            good_d  = '0;
            miss_d  = '0;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (s.s_data == exp_q) begin
            exp_d  = D_WIDTH'(seq_next(mode_q, 64'(exp_q), D_WIDTH));
            miss_d = '0;
            if (good_q != GoodW'(LOCK_GOOD)) good_d = good_q + 1'b1;
            if (good_d == GoodW'(LOCK_GOOD)) begin
              lock_d      = 1'b1;
              ever_lock_d = 1'b1;
            end
          end else begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (ever_lock_q) err_sticky_d = 1'b1;
            good_d = '0;
            // Resync in place so a single bad word costs one error, not a burst.
            exp_d  = D_WIDTH'(seq_next(mode_q, 64'(s.s_data), D_WIDTH));
            miss_d = miss_q + 1'b1;
            if (miss_d == MissW'(LOCK_MISS)) begin
              lock_d  = 1'b0;
              miss_d  = '0;
              state_d = SYNC;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // Checker state; clr behaves like reset and discards a coincident transfer.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q      <= SYNC;
      mode_q       <= MODE_CNT;
      exp_q        <= '0;
      good_q       <= '0;
      miss_q       <= '0;
      lock_q       <= 1'b0;
      ever_lock_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      word_cnt_q   <= '0;
      hb_q         <= 1'b0;
      msb_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      exp_q        <= exp_d;
      good_q       <= good_d;
      miss_q       <= miss_d;
      lock_q       <= lock_d;
      ever_lock_q  <= ever_lock_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      word_cnt_q   <= word_cnt_d;
      hb_q         <= hb_d;
      msb_q        <= msb_d;
    end
  end

`ifdef STREAM_SEQ_CHECKER_GAP_STATS_EN
  logic [15:0] gap_q, gap_d;
  logic [15:0] gap_max_q, gap_max_d;
  logic        gap_run_q, gap_run_d;

  // Idle-run measurement; counting starts only once the first word has been seen.
  always_comb begin
    gap_d     = gap_q;
    gap_max_d = gap_max_q;
    gap_run_d = gap_run_q;
    if (xfer) begin
      if (gap_q > gap_max_q) gap_max_d = gap_q;
      gap_d     = 16'd0;
      gap_run_d = 1'b1;
    end else if (gap_run_q && !s.s_valid && gap_q != 16'hFFFF) begin
      gap_d = gap_q + 16'd1;
    end
  end

  // Gap statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      gap_q     <= 16'd0;
      gap_max_q <= 16'd0;
      gap_run_q <= 1'b0;
    end else begin
      gap_q     <= gap_d;
      gap_max_q <= gap_max_d;
      gap_run_q <= gap_run_d;
    end
  end

  assign gap_max = gap_max_q;
`else
  assign gap_max = 16'd0;
`endif

  assign lock       = lock_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign word_cnt   = word_cnt_q;
  assign leds       = LED_ACTIVE_LOW ? ~{msb_q, hb_q, err_sticky_q, lock_q}
                                     : {msb_q, hb_q, err_sticky_q, lock_q};

endmodule

// File: tb/tb_stream_seq_checker.sv
// Bench: 32-bit instance for counter tests, 16-bit instance for LFSR tests (heartbeat every 8).
module tb_stream_seq_checker;

  typedef struct {
    logic [63:0] data;
    bit          restart;
    bit          lfsr;
    logic        lock;
    logic [15:0] err;
    logic        sticky;
  } vec_t;

  typedef struct {
    logic        lock;
    logic [15:0] err;
    logic        sticky;
    logic [31:0] words;
    logic [3:0]  leds;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [7:0]  cfg_div = 8'd0;
  logic        valid = 1'b0;
  logic [63:0] data = '0;
  logic        sel16 = 1'b0;

  logic        lock32, sticky32, lock16, sticky16;
  logic [15:0] err32, err16, gap32, gap16;
  logic [31:0] wc32, wc16;
  logic [3:0]  leds32, leds16;

  logic        rdy, lock_m, sticky_m;
  logic [15:0] err_m, gap_m;
  logic [31:0] wc_m;
  logic [3:0]  leds_m;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned wc = 0;
  exp_t        sb[$];
  vec_t        vecs[$];

  always #5 clk = ~clk;

  stream_seq_checker_if #(.D_WIDTH(32)) if32 ();
  stream_seq_checker_if #(.D_WIDTH(16)) if16 ();

  assign if32.s_valid = valid & ~sel16;
  assign if32.s_data  = data[31:0];
  assign if16.s_valid = valid & sel16;
  assign if16.s_data  = data[15:0];

  assign rdy      = sel16 ? if16.s_ready : if32.s_ready;
  assign lock_m   = sel16 ? lock16 : lock32;
  assign sticky_m = sel16 ? sticky16 : sticky32;
  assign err_m    = sel16 ? err16 : err32;
  assign wc_m     = sel16 ? wc16 : wc32;
  assign leds_m   = sel16 ? leds16 : leds32;
  assign gap_m    = sel16 ? gap16 : gap32;

  stream_seq_checker #(.D_WIDTH(32), .HB_SHIFT(3)) u_dut32 (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .cfg_mode      (cfg_mode),
    .cfg_ready_div (cfg_div),
    .s             (if32),
    .lock          (lock32),
    .err_sticky    (sticky32),
    .err_cnt       (err32),
    .word_cnt      (wc32),
    .gap_max       (gap32),
    .leds          (leds32)
  );

  stream_seq_checker #(.D_WIDTH(16), .HB_SHIFT(3)) u_dut16 (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .cfg_mode      (cfg_mode),
    .cfg_ready_div (cfg_div),
    .s             (if16),
    .lock          (lock16),
    .err_sticky    (sticky16),
    .err_cnt       (err16),
    .word_cnt      (wc16),
    .gap_max       (gap16),
    .leds          (leds16)
  );

  function automatic logic [15:0] lnext16(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic vec_t mk(input logic [63:0] d, input bit rs, input bit lf, input logic lk,
                              input logic [15:0] er, input logic st);
    vec_t v;
    v.data = d; v.restart = rs; v.lfsr = lf; v.lock = lk; v.err = er; v.sticky = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ready"}, rdy, 0);
    chk({tag, "_lock"}, lock_m, 0);
    chk({tag, "_sticky"}, sticky_m, 0);
    chk({tag, "_err"}, err_m, 0);
    chk({tag, "_words"}, wc_m, 0);
    chk({tag, "_leds"}, leds_m, 4'hF);
    chk({tag, "_gap"}, gap_m, 0);
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    wc = 0;
  endtask

  // Drive one word, wait for ready (bounded), then compare against the queued expectation.
  task automatic send(input logic [63:0] d, input exp_t e);
    int   n;
    exp_t q;
    n = 0;
    @(negedge clk); valid = 1'b1; data = d; sb.push_back(e);
    while (!rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: got 0, want 1");
    end
    @(posedge clk); #1; valid = 1'b0;
    q = sb.pop_front();
    chk("lock", lock_m, q.lock);
    chk("err_cnt", err_m, q.err);
    chk("err_sticky", sticky_m, q.sticky);
    chk("word_cnt", wc_m, q.words);
    chk("leds", leds_m, q.leds);
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    logic msb, hb;
    if (v.restart) begin
      sel16 = v.lfsr; cfg_mode = v.lfsr;
      do_clr();
    end
    wc++;
    hb = ((wc >> 3) & 1) != 0;
    msb = sel16 ? v.data[15] : v.data[31];
    e.lock = v.lock; e.err = v.err; e.sticky = v.sticky; e.words = 32'(wc);
    e.leds = ~{msb, hb, v.sticky, v.lock};
    send(v.data, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [15:0] x;
    logic [15:0] gap_exp;

    // Counter lock, single error, loss of lock, resync.
    for (int i = 0; i <= 10; i++) vecs.push_back(mk(i, i == 0, 0, i >= 8, 0, 0));
    vecs.push_back(mk(64'h100, 0, 0, 1, 1, 1));
    vecs.push_back(mk(64'h101, 0, 0, 1, 1, 1));
    vecs.push_back(mk(64'h102, 0, 0, 1, 1, 1));
    vecs.push_back(mk(64'h5000, 0, 0, 1, 2, 1));
    vecs.push_back(mk(64'h7000, 0, 0, 1, 3, 1));
    vecs.push_back(mk(64'h9000, 0, 0, 1, 4, 1));
    vecs.push_back(mk(64'hB000, 0, 0, 0, 5, 1));
    vecs.push_back(mk(64'h20, 0, 0, 0, 5, 1));
    vecs.push_back(mk(64'h21, 0, 0, 0, 5, 1));
    // Counter wrap through all-ones after lock.
    w = 32'hFFFF_FFF4;
    for (int i = 0; i < 14; i++) begin
      vecs.push_back(mk(64'(w), i == 0, 0, i >= 8, 0, 0));
      w = w + 32'd1;
    end
    // LFSR: zero seed ignored, lock from 0xACE1, then a flipped bit.
    vecs.push_back(mk(64'h0, 1, 1, 0, 0, 0));
    x = 16'hACE1;
    for (int i = 0; i <= 8; i++) begin
      vecs.push_back(mk(64'(x), 0, 1, i >= 8, 0, 0));
      x = lnext16(x);
    end
    vecs.push_back(mk(64'(x ^ 16'h0001), 0, 1, 1, 1, 1));
    vecs.push_back(mk(64'(lnext16(x ^ 16'h0001)), 0, 1, 1, 1, 1));

    // Power-on reset and first ready.
    idle(3); #1;
    chk_rst("por");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_ready", rdy, 1);

    foreach (vecs[i]) apply(vecs[i]);

    sel16 = 1'b0; cfg_mode = 1'b0;

    // Throttle pattern with divide-by-3.
    cfg_div = 8'd2;
    do_clr();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("ready_div2", rdy, (i % 3) == 0);
    end
    apply(mk(64'h40, 0, 0, 0, 0, 0));
    apply(mk(64'h41, 0, 0, 0, 0, 0));
    cfg_div = 8'd0;

    // clr coincident with a transfer.
    do_clr();
    for (int i = 0; i < 4; i++) apply(mk(i, 0, 0, 0, 0, 0));
    @(negedge clk); valid = 1'b1; data = 64'd4; clr = 1'b1;
    @(posedge clk); #1;
    chk_rst("clr");
    clr = 1'b0; valid = 1'b0; wc = 0;

    // Reset pulse while locked.
    do_clr();
    for (int i = 0; i < 10; i++) apply(mk(i, 0, 0, i >= 8, 0, 0));
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk_rst("rst");
    rst_n = 1'b1; wc = 0;

    // Gap statistics.
`ifdef STREAM_SEQ_CHECKER_GAP_STATS_EN
    gap_exp = 16'd7;
`else
    gap_exp = 16'd0;
`endif
    do_clr();
    idle(5);
    apply(mk(64'h0, 0, 0, 0, 0, 0));
    chk("gap_before_first", gap_m, 0);
    idle(7);
    apply(mk(64'h1, 0, 0, 0, 0, 0));
    chk("gap_7", gap_m, gap_exp);
    idle(3);
    apply(mk(64'h2, 0, 0, 0, 0, 0));
    chk("gap_keep_max", gap_m, gap_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
